// File: rtl/dfr_axil_pkg.sv
// Shared types and constants for the DFR AXI4-Lite command master.
// Opcodes, AXI response codes and the dfr_core_top address map.
package dfr_axil_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] REG_CTRL           = 32'h0000_0000;
    localparam logic [31:0] REG_RESERVOIR_NODE = 32'h0000_0024;

    localparam logic [31:0] MEM_INPUT     = 32'h0100_0000;
    localparam logic [31:0] MEM_RESERVOIR = 32'h0200_0000;
    localparam logic [31:0] MEM_WEIGHT    = 32'h0300_0000;
    localparam logic [31:0] MEM_OUTPUT    = 32'h0400_0000;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_BUSY_BIT     = 1;
    localparam int CTRL_PRESERVE_BIT = 2;

endpackage

// File: rtl/dfr_axil_cmd_master.sv
// AXI4-Lite initiator executing WRITE / READ / POLL commands.
// One transaction outstanding; response held until consumed.
module dfr_axil_cmd_master
    import dfr_axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_GAP_CYCLES    = 16,
    parameter int POLL_MAX_TRIES     = 65535
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [15:0]                     rsp_tries,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int TW_RAW = $clog2(POLL_MAX_TRIES + 1);
    localparam int TW     = (TW_RAW > 16) ? TW_RAW : 16;
    localparam int GW     = (POLL_GAP_CYCLES > 1) ? $clog2(POLL_GAP_CYCLES) : 1;

    localparam logic [TW-1:0] MAX_TRIES = TW'(POLL_MAX_TRIES);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(POLL_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_GAP, S_RSP
    } state_t;

    state_t          state_q;
    op_t             op_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   mask_q;
    logic            awvalid_q, wvalid_q, bready_q;
    logic            arvalid_q, rready_q, cmd_ready_q;
    logic            rsp_valid_q, rsp_timeout_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic [1:0]      rsp_resp_q;
    logic [15:0]     rsp_tries_q;
    logic [TW-1:0]   tries_q;
    logic [GW-1:0]   gap_q;

    logic            aw_ok_d, w_ok_d, poll_hit_d, poll_again_d;

    // Tries counter wider than the response field clamps to all-ones.
    function automatic logic [15:0] sat16(input logic [TW-1:0] v);
        if (v > TW'(16'hFFFF)) return 16'hFFFF;
        return v[15:0];
    endfunction

    // Handshake completion and poll match decode for the current beat.
    always_comb begin
        aw_ok_d      = !awvalid_q || M_AXI_AWREADY;
        w_ok_d       = !wvalid_q  || M_AXI_WREADY;
        poll_hit_d   = ((M_AXI_RDATA ^ wdata_q) & mask_q) == '0;
        poll_again_d = (op_q == OP_POLL) && (M_AXI_RRESP == RESP_OKAY)
                       && !poll_hit_d;
    end

    // Command FSM with registered channel and response outputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q       <= S_IDLE;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_tries_q   <= '0;
            tries_q       <= '0;
            gap_q         <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= op_t'(cmd_op);
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        mask_q      <= cmd_mask;
                        tries_q     <= '0;
                        unique case (op_t'(cmd_op))
                            OP_WRITE: begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= S_WR;
                            end
                            OP_READ, OP_POLL: begin
                                arvalid_q <= 1'b1;
                                state_q   <= S_RD_AR;
                            end
                            default: begin
                                rsp_rdata_q   <= '0;
                                rsp_resp_q    <= RESP_SLVERR;
                                rsp_tries_q   <= '0;
                                rsp_timeout_q <= 1'b0;
                                rsp_valid_q   <= 1'b1;
                                state_q       <= S_RSP;
                            end
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WR: begin
                    if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && M_AXI_WREADY) wvalid_q <= 1'b0;
                    if (aw_ok_d && w_ok_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (M_AXI_BVALID) begin
                        bready_q      <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= M_AXI_BRESP;
                        rsp_tries_q   <= '0;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RSP;
                    end
                end
                S_RD_AR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tries_q   <= tries_q + 1'b1;
                        state_q   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        rsp_tries_q <= sat16(tries_q);
                        if (poll_again_d && tries_q != MAX_TRIES) begin
                            gap_q   <= GAP_LOAD;
                            state_q <= S_GAP;
                        end else begin
                            rsp_timeout_q <= poll_again_d;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= S_RSP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_AR;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign rsp_tries     = rsp_tries_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_dfr_axil_cmd_master.sv
// Directed bench for dfr_axil_cmd_master with a behavioural
// AXI4-Lite slave and a response scoreboard.
module tb_dfr_axil_cmd_master;
    import dfr_axil_pkg::*;

    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int GAP  = 4;
    localparam int MAXT = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [15:0]   rsp_tries;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    dfr_axil_cmd_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .POLL_GAP_CYCLES    (GAP),
        .POLL_MAX_TRIES     (MAXT)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_mask      (cmd_mask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .rsp_tries     (rsp_tries),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // Slave configuration, written only by the stimulus block
    int          aw_delay = 0;
    int          w_delay = 0;
    int          busy_until = 0;
    logic [31:0] rd_val = '0;
    logic [1:0]  rd_resp = 2'b00;
    logic [1:0]  wr_resp = 2'b00;

    // Slave state and observation, written only by the slave block
    int          cyc = 0;
    int          aw_cnt = 0, w_cnt = 0;
    int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic        w_drop_aw_held = 1'b0;
    int          ar_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!wvalid && awvalid) w_drop_aw_held <= 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
            arready <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1;
                aw_beats <= aw_beats + 1; last_awaddr <= awaddr;
            end else if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1;
                w_beats <= w_beats + 1;
                last_wdata <= wdata; last_wstrb <= wstrb;
            end else if (wvalid && !w_got) begin
                if (w_cnt >= w_delay) wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_beats <= b_beats + 1;
            end else if (!bvalid
                         && (aw_got || (awvalid && awready))
                         && (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1; bresp <= wr_resp;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (arvalid && arready) begin
                arready <= 1'b0; rvalid <= 1'b1;
                rdata <= (ar_beats < busy_until) ? 32'h2 : rd_val;
                rresp <= rd_resp;
                ar_beats <= ar_beats + 1; last_araddr <= araddr;
                ar_cyc.push_back(cyc);
            end else if (arvalid) begin
                arready <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        logic [15:0] tries;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input op_t op,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [31:0] mk, input logic [31:0] er,
                          input logic [1:0] ers, input logic eto,
                          input logic [15:0] etr);
        exp_t e;
        bit   ok;
        e.rdata = er; e.resp = ers; e.to = eto; e.tries = etr;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        cmd_wdata = wd; cmd_mask = mk;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++)
            if (cmd_ready) ok = 1; else @(negedge clk);
        chk({tag, "_accept"}, 64'(ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++)
            if (rsp_valid) ok = 1; else @(negedge clk);
        chk({tag, "_rsp_seen"}, 64'(ok), 64'd1);
        e = sb.pop_front();
        if (ok) begin
            chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            chk({tag, "_resp"}, 64'(rsp_resp), 64'(e.resp));
            chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
            chk({tag, "_tries"}, 64'(rsp_tries), 64'(e.tries));
            chk({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
            @(negedge clk);
            chk({tag, "_rsp_held"}, 64'(rsp_valid), 64'd1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        int aw0, w0, b0, ar0, n0, mg, seen;
        bit ok;

        repeat (3) @(negedge clk);
        chk("reset_ctrl",
            64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                 rsp_valid, rsp_timeout}), 64'd0);
        chk("reset_data", 64'({rsp_rdata, rsp_resp, rsp_tries, awaddr}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Plain write, slave ready immediately
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        do_cmd("wr1", OP_WRITE, 30'h8, 32'h1, 32'h0,
               32'h0, RESP_OKAY, 1'b0, 16'd0);
        chk("wr1_aw_beats", 64'(aw_beats - aw0), 64'd1);
        chk("wr1_w_beats", 64'(w_beats - w0), 64'd1);
        chk("wr1_b_beats", 64'(b_beats - b0), 64'd1);
        chk("wr1_awaddr", 64'(last_awaddr), 64'h8);
        chk("wr1_wdata", 64'(last_wdata), 64'h1);
        chk("wr1_wstrb", 64'(last_wstrb), 64'hF);

        // W accepted three cycles before AW
        aw_delay = 3;
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        do_cmd("wr2", OP_WRITE, AW'(REG_RESERVOIR_NODE), 32'hABCD_1234,
               32'h0, 32'h0, RESP_OKAY, 1'b0, 16'd0);
        aw_delay = 0;
        chk("wr2_w_drop_aw_held", 64'(w_drop_aw_held), 64'd1);
        chk("wr2_aw_beats", 64'(aw_beats - aw0), 64'd1);
        chk("wr2_w_beats", 64'(w_beats - w0), 64'd1);
        chk("wr2_b_beats", 64'(b_beats - b0), 64'd1);
        chk("wr2_awaddr", 64'(last_awaddr), 64'h24);
        chk("wr2_wdata", 64'(last_wdata), 64'hABCD_1234);

        // Write with error response
        wr_resp = RESP_SLVERR;
        do_cmd("wr_err", OP_WRITE, AW'(MEM_WEIGHT), 32'h5, 32'h0,
               32'h0, RESP_SLVERR, 1'b0, 16'd0);
        wr_resp = RESP_OKAY;

        // Single read
        rd_val = 32'd300;
        ar0 = ar_beats;
        do_cmd("rd1", OP_READ, AW'(MEM_INPUT + 32'h4), 32'h0, 32'h0,
               32'd300, RESP_OKAY, 1'b0, 16'd1);
        chk("rd1_ar_beats", 64'(ar_beats - ar0), 64'd1);
        chk("rd1_araddr", 64'(last_araddr), 64'h0100_0004);

        // Poll CTRL busy bit, busy for three reads
        rd_val = 32'h1;
        busy_until = ar_beats + 3;
        n0 = ar_cyc.size();
        do_cmd("poll_ok", OP_POLL, AW'(REG_CTRL), 32'h0,
               32'h1 << CTRL_BUSY_BIT, 32'h1, RESP_OKAY, 1'b0, 16'd4);
        chk("poll_ok_ar_beats", 64'(ar_cyc.size() - n0), 64'd4);
        mg = 1000;
        for (int i = n0 + 1; i < ar_cyc.size(); i++)
            if (ar_cyc[i] - ar_cyc[i-1] < mg) mg = ar_cyc[i] - ar_cyc[i-1];
        chk("poll_ok_gap", 64'(mg >= GAP), 64'd1);

        // Poll never clearing exhausts its tries
        busy_until = ar_beats + 1000;
        n0 = ar_cyc.size();
        do_cmd("poll_to", OP_POLL, AW'(REG_CTRL), 32'h0, 32'h2,
               32'h2, RESP_OKAY, 1'b1, 16'(MAXT));
        chk("poll_to_ar_beats", 64'(ar_cyc.size() - n0), 64'(MAXT));
        busy_until = 0;

        // Read error response
        rd_val = 32'hDEAD;
        rd_resp = RESP_SLVERR;
        do_cmd("rd_err", OP_READ, AW'(MEM_OUTPUT), 32'h0, 32'h0,
               32'hDEAD, RESP_SLVERR, 1'b0, 16'd1);

        // Poll aborts on first error response
        n0 = ar_cyc.size();
        do_cmd("poll_err", OP_POLL, AW'(REG_CTRL), 32'h0, 32'h2,
               32'hDEAD, RESP_SLVERR, 1'b0, 16'd1);
        chk("poll_err_ar_beats", 64'(ar_cyc.size() - n0), 64'd1);
        rd_resp = RESP_OKAY;

        // Reserved opcode: error response, no bus traffic
        aw0 = aw_beats; ar0 = ar_beats;
        do_cmd("rsvd", OP_RSVD, AW'(MEM_RESERVOIR), 32'h0, 32'h0,
               32'h0, RESP_SLVERR, 1'b0, 16'd0);
        chk("rsvd_no_traffic", 64'((aw_beats - aw0) + (ar_beats - ar0)), 64'd0);

        // Reset while AWVALID is pending
        aw_delay = 10;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_WRITE;
        cmd_addr = 30'h10; cmd_wdata = 32'h77;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++)
            if (cmd_ready) ok = 1; else @(negedge clk);
        chk("rst_accept", 64'(ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_awvalid", 64'(awvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valids",
            64'({awvalid, wvalid, arvalid, bready, rready, cmd_ready,
                 rsp_valid}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aw_delay = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || awvalid) seen++;
        end
        chk("rst_no_rsp", 64'(seen), 64'd0);
        aw0 = aw_beats;
        do_cmd("wr_after_rst", OP_WRITE, 30'h14, 32'h99, 32'h0,
               32'h0, RESP_OKAY, 1'b0, 16'd0);
        chk("wr_after_rst_aw", 64'(aw_beats - aw0), 64'd1);
        chk("wr_after_rst_wdata", 64'(last_wdata), 64'h99);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
